// File: rtl/pulse_stretch_timer.sv
// Retriggerable-queue pulse stretcher: each trig yields HOLD_CYCLES of out high followed by a GAP_CYCLES low gap.
// Optional macro PULSE_RETRIGGER_EN: a trig during HOLD extends the current pulse instead of queueing.
module pulse_stretch_timer #(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 100,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic              clear,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0]  HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(0);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_next;
  logic [PEND_W-1:0]  pending_next;
  logic               overflow_next;
  logic               enqueue;

  // Next-state, timer and queue bookkeeping.
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    pending_next  = pending;
    overflow_next = overflow;
    enqueue       = 1'b0;

    case (state)
      IDLE: begin
        if (trig) begin
          state_next = HOLD;
          timer_next = HOLD_LOAD;
        end else begin
          timer_next = TMR_ZERO;
        end
      end
      HOLD: begin
`ifdef PULSE_RETRIGGER_EN
        if (trig) begin
          timer_next = HOLD_LOAD;
        end else if (timer == TMR_ZERO) begin
          state_next = GAP;
          timer_next = GAP_LOAD;
        end else begin
          timer_next = timer - TMR_ONE;
        end
`else
        if (timer == TMR_ZERO) begin
          state_next = GAP;
          timer_next = GAP_LOAD;
        end else begin
          timer_next = timer - TMR_ONE;
        end
        enqueue = trig;
`endif
      end
      GAP: begin
        if (timer == TMR_ZERO) begin
          // A trig arriving on the dequeue edge is consumed directly (net zero on pending).
          if (trig || (pending != PEND_ZERO)) begin
            state_next = HOLD;
            timer_next = HOLD_LOAD;
            if (!trig) begin
              pending_next = pending - PEND_ONE;
            end else begin
              pending_next = pending;
            end
          end else begin
            state_next = IDLE;
            timer_next = TMR_ZERO;
          end
        end else begin
          timer_next = timer - TMR_ONE;
          enqueue    = trig;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = TMR_ZERO;
      end
    endcase

    if (enqueue) begin
      if (pending == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending + PEND_ONE;
      end
    end else begin
      overflow_next = overflow_next;
    end

    if (clear) begin
      state_next    = IDLE;
      timer_next    = TMR_ZERO;
      pending_next  = PEND_ZERO;
      overflow_next = 1'b0;
    end else begin
      state_next = state_next;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= TMR_ZERO;
      pending  <= PEND_ZERO;
      overflow <= 1'b0;
      out      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      pending  <= pending_next;
      overflow <= overflow_next;
      out      <= (state_next == HOLD);
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretch_timer.sv
// Self-checking bench for pulse_stretch_timer (HOLD=4, GAP=2, PEND_W=2): directed scenarios plus random traffic vs a remaining-time model.
module tb_pulse_stretch_timer;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk;
  logic          reset;
  logic          trig;
  logic          clear;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int total;
  int bad;
  int cyc;

  pulse_stretch_timer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk(clk), .reset(reset), .trig(trig), .clear(clear),
    .out(out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: cycles of high time left, cycles of gap left, queued count, sticky drop flag.
  typedef struct {
    int hold_left;
    int gap_left;
    int pend;
    int ovf;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, int t, int c);
    model_t n;
    int enq;
    n = s;
    enq = 0;
    if (c != 0) begin
      n.hold_left = 0; n.gap_left = 0; n.pend = 0; n.ovf = 0;
    end else if (s.hold_left > 0) begin
      n.hold_left = s.hold_left - 1;
      if (n.hold_left == 0) n.gap_left = G;
`ifdef PULSE_RETRIGGER_EN
      if (t != 0) begin
        n.hold_left = H;
        n.gap_left  = 0;
      end
`else
      enq = t;
`endif
    end else if (s.gap_left > 0) begin
      n.gap_left = s.gap_left - 1;
      if (n.gap_left == 0) begin
        if (s.pend + t > 0) begin
          n.hold_left = H;
          n.pend = s.pend + t - 1;
        end
      end else begin
        enq = t;
      end
    end else if (t != 0) begin
      n.hold_left = H;
    end
    if (enq != 0) begin
      if (n.pend == PMAX) n.ovf = 1;
      else n.pend = n.pend + 1;
    end
    return n;
  endfunction

  // Model advance on each edge, async reset as in the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{0, 0, 0, 0};
    else       m <= step(m, int'(trig), int'(clear));
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d t=%0t", name, act, exp, cyc, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("cmp_out",      int'(out),      (m.hold_left > 0) ? 1 : 0);
    chk("cmp_busy",     int'(busy),     (m.hold_left > 0 || m.gap_left > 0) ? 1 : 0);
    chk("cmp_pending",  int'(pending),  m.pend);
    chk("cmp_overflow", int'(overflow), m.ovf);
  end

  task automatic run_to(int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    trig  = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse(int c);
    run_to(c);
    trig = 1'b1;
    run_to(c + 1);
    trig = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    trig  = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    #3;
    chk("rst_out",      int'(out),      0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_pending",  int'(pending),  0);
    chk("rst_overflow", int'(overflow), 0);

    // Single event
    do_reset();
    pulse(10);
    chk("s1_out11", int'(out), 1);
    chk("s1_mdl11", m.hold_left, H);
    run_to(14); chk("s1_out14", int'(out), 1);
    run_to(15); chk("s1_out15", int'(out), 0); chk("s1_busy15", int'(busy), 1);
    run_to(16); chk("s1_busy16", int'(busy), 1);
    run_to(17); chk("s1_busy17", int'(busy), 0);

    // Two events two cycles apart
    do_reset();
    pulse(10);
    pulse(12);
`ifdef PULSE_RETRIGGER_EN
    chk("s2_pend13", int'(pending), 0);
    run_to(16); chk("s2_out16", int'(out), 1);
    run_to(17); chk("s2_out17", int'(out), 0); chk("s2_pend17", int'(pending), 0);
`else
    chk("s2_pend13", int'(pending), 1);
    chk("s2_mdlp13", m.pend, 1);
    run_to(16); chk("s2_out16", int'(out), 0);
    run_to(17); chk("s2_out17", int'(out), 1); chk("s2_pend17", int'(pending), 0);
    run_to(20); chk("s2_out20", int'(out), 1);
    run_to(21); chk("s2_out21", int'(out), 0);
`endif

`ifndef PULSE_RETRIGGER_EN
    // Saturation and sticky overflow
    do_reset();
    pulse(10); pulse(12); pulse(13); pulse(14);
    chk("s3_pend15", int'(pending), 3);
    chk("s3_ovf15", int'(overflow), 0);
    pulse(15);
    chk("s3_pend16", int'(pending), 3);
    chk("s3_ovf16", int'(overflow), 1);
    run_to(60);
    chk("s3_busy60", int'(busy), 0);
    chk("s3_ovf60", int'(overflow), 1);
`endif

    // Clear beats a simultaneous trig
    do_reset();
    pulse(10);
    run_to(12);
    clear = 1'b1; trig = 1'b1;
    run_to(13);
    clear = 1'b0; trig = 1'b0;
    chk("s4_out13", int'(out), 0);
    chk("s4_busy13", int'(busy), 0);
    chk("s4_pend13", int'(pending), 0);
    run_to(20); chk("s4_busy20", int'(busy), 0);

    // Async reset mid-HOLD with a queue, then a clean pulse
    do_reset();
    pulse(10); pulse(11); pulse(12);
`ifndef PULSE_RETRIGGER_EN
    chk("s5_pend13", int'(pending), 2);
`endif
    chk("s5_out13", int'(out), 1);
    #2 reset = 1'b1;
    #1;
    chk("s5_rout", int'(out), 0);
    chk("s5_rbusy", int'(busy), 0);
    chk("s5_rpend", int'(pending), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    pulse(2);
    chk("s5_out3", int'(out), 1);
    run_to(6); chk("s5_out6", int'(out), 1);
    run_to(7); chk("s5_out7", int'(out), 0);
    run_to(20); chk("s5_busy20", int'(busy), 0); chk("s5_pend20", int'(pending), 0);

    // Random traffic checked by the compare process
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cyc++;
      trig  = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
      end
    end
    trig  = 1'b0;
    clear = 1'b0;
    run_to(cyc + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
